cpu_tick_ctrl: RTL and testbench

- Parametrised successor to the fixed 1 s ripple-carry tick generator.
- Produces a single-cycle clock-enable pulse, tick_o, for the single-cycle MIPS data path.
- Adds runtime-selectable divide ratios, HALT/RUN/STEP/FAST modes, a debounced single-step pushbutton and an optional tick counter.
- Sits between the PLL output clock and the data path enable, driven directly from board switches and a key.

---
 rtl/cpu_tick_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cpu_tick_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_tick_ctrl.sv
// cpu_tick_ctrl
//   Clock-enable generator for the single-cycle MIPS data path. It produces a
//   one-cycle tick_o pulse at a runtime-selectable rate (RUN), on every cycle
//   (FAST), once per debounced pushbutton press (STEP), or never (HALT).
//
//   Optional feature: define CPU_TICK_CNT_EN to add the tick_cnt_o port, a
//   wrapping count of issued ticks that only reset clears.
//
// Ports
//   clk         in   system clock (PLL output)
//   reset       in   asynchronous active-low reset
//   mode_i      in   [1:0] 00 HALT, 01 RUN, 10 STEP, 11 FAST (asynchronous source)
//   rate_sel_i  in   [1:0] RUN divisor select, DIV0..DIV3 (asynchronous source)
//   step_btn_i  in   raw step pushbutton, active-high (asynchronous source)
//   tick_o      out  registered one-cycle enable pulse
//   running_o   out  registered, high while in RUN or FAST
//   tick_cnt_o  out  [CNT_W-1:0] issued-tick count (CPU_TICK_CNT_EN only)
//
// State table
//   state | meaning
//   HALT  | no ticks, divider held at 0
//   RUN   | divider counts, tick when cnt reaches div-1
//   STEP  | one tick per debounced button press
//   FAST  | tick on every cycle, divider held at 0
module cpu_tick_ctrl #(
  parameter int DIV_W        = 26,
  parameter int DIV0         = 10_000_000,
  parameter int DIV1         = 2_500_000,
  parameter int DIV2         = 250_000,
  parameter int DIV3         = 1,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode_i,
  input  logic [1:0]       rate_sel_i,
  input  logic             step_btn_i,
  output logic             tick_o,
  output logic             running_o
`ifdef CPU_TICK_CNT_EN
  ,
  output logic [CNT_W-1:0] tick_cnt_o
`endif
);

  // State encoding equals the mode_i encoding, so the synchronized mode is
  // directly the next state.
  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;
  localparam logic [1:0] ST_FAST = 2'b11;

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  localparam logic [DIV_W-1:0] DIV0_M1 = DIV_W'(DIV0 - 1);
  localparam logic [DIV_W-1:0] DIV1_M1 = DIV_W'(DIV1 - 1);
  localparam logic [DIV_W-1:0] DIV2_M1 = DIV_W'(DIV2 - 1);
  localparam logic [DIV_W-1:0] DIV3_M1 = DIV_W'(DIV3 - 1);

  function automatic bit div_ok(input longint d);
    return (d >= 1) && (d < (longint'(1) << DIV_W));
  endfunction

  generate
    if (!div_ok(DIV0) || !div_ok(DIV1) || !div_ok(DIV2) || !div_ok(DIV3)) begin : g_bad_div
      $error("cpu_tick_ctrl: every DIVn must lie in 1 .. 2**DIV_W-1");
    end
    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
      $error("cpu_tick_ctrl: DEBOUNCE_CYC must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("cpu_tick_ctrl: CNT_W must be at least 1");
    end
  endgenerate

  // Synchronizers. The state register doubles as the second mode stage, so
  // a mode change takes effect two clocks after it reaches the pin.
  logic [1:0]       mode_meta;
  logic [1:0]       state;
  logic [1:0]       rate_meta;
  logic [1:0]       rate_sync;
  logic             btn_meta;
  logic             btn_sync;

  logic             btn_db;
  logic [DB_W-1:0]  db_cnt;
  logic             db_accept;
  logic             step_rise;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_m1;
  logic             transition;
  logic             run_hit;
  logic             tick_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_meta <= ST_HALT;
      state     <= ST_HALT;
      rate_meta <= 2'd0;
      rate_sync <= 2'd0;
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
    end else begin
      mode_meta <= mode_i;
      state     <= mode_meta;
      rate_meta <= rate_sel_i;
      rate_sync <= rate_meta;
      btn_meta  <= step_btn_i;
      btn_sync  <= btn_meta;
    end
  end

  always_comb begin
    div_m1 = DIV0_M1;
    case (rate_sync)
      2'd0:    div_m1 = DIV0_M1;
      2'd1:    div_m1 = DIV1_M1;
      2'd2:    div_m1 = DIV2_M1;
      default: div_m1 = DIV3_M1;
    endcase
  end

  // The debounced level moves only after the synchronized button has
  // differed from it for DEBOUNCE_CYC consecutive cycles.
  assign db_accept = (btn_sync != btn_db) && (db_cnt == DB_LAST);
  assign step_rise = db_accept && btn_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_sync == btn_db) begin
      db_cnt <= '0;
    end else if (db_accept) begin
      btn_db <= btn_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign transition = (mode_meta != state);
  // ">=" rather than "==" so that shrinking the divisor below the current
  // count fires on the next cycle instead of wrapping the counter.
  assign run_hit    = (cnt >= div_m1);

  always_comb begin
    tick_next = 1'b0;
    case (state)
      ST_RUN:  tick_next = run_hit;
      ST_STEP: tick_next = step_rise;
      ST_FAST: tick_next = 1'b1;
      default: tick_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      tick_o    <= 1'b0;
      running_o <= 1'b0;
    end else begin
      tick_o    <= tick_next;
      running_o <= (mode_meta == ST_RUN) || (mode_meta == ST_FAST);
      if (transition || (state != ST_RUN) || run_hit) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

`ifdef CPU_TICK_CNT_EN
  // Counts on the same edge that raises tick_o, so the value always
  // includes the pulse currently visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_o <= '0;
    end else if (tick_next) begin
      tick_cnt_o <= tick_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_tick_ctrl.sv
module tb_cpu_tick_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] mode_i;
  logic [1:0] rate_sel_i;
  logic       step_btn_i;
  logic       tick_o;
  logic       running_o;
`ifdef CPU_TICK_CNT_EN
  logic [3:0] tick_cnt_o;
`endif

  cpu_tick_ctrl #(
    .DIV_W(26), .DIV0(4), .DIV1(8), .DIV2(16), .DIV3(1),
    .DEBOUNCE_CYC(3), .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode_i(mode_i),
    .rate_sel_i(rate_sel_i),
    .step_btn_i(step_btn_i),
    .tick_o(tick_o),
    .running_o(running_o)
`ifdef CPU_TICK_CNT_EN
    ,
    .tick_cnt_o(tick_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: absolute edge index of every observed tick pulse.
  int tick_q[$];
  always @(negedge clk) if (reset && tick_o) tick_q.push_back(cyc);

  int n_checks = 0;
  int n_errors = 0;
  int base = 0;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] rate;
    int         n;
    int         exp_ticks;
    int         exp_first;
    int         exp_run;
  } vec_t;

  vec_t vecs[7];
  vec_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [1:0] r, input logic b);
    reset      = 1'b0;
    mode_i     = m;
    rate_sel_i = r;
    step_btn_i = b;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tick", int'(tick_o), 0);
    chk("rst_running", int'(running_o), 0);
`ifdef CPU_TICK_CNT_EN
    chk("rst_tick_cnt", int'(tick_cnt_o), 0);
`endif
    reset = 1'b1;
    base  = cyc;
    tick_q.delete();
  endtask

  function automatic int first_tick();
    return (tick_q.size() > 0) ? (tick_q[0] - base) : 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    int   press;

    // Edge numbers count rising edges after reset release. The state
    // register sees the mode after edge 2; the first RUN tick is then div
    // edges later, FAST ticks from edge 3 on.
    vecs[0] = '{2'b01, 2'd0, 20, 4,  6,  1};
    vecs[1] = '{2'b01, 2'd1, 20, 2,  10, 1};
    vecs[2] = '{2'b01, 2'd2, 20, 1,  18, 1};
    vecs[3] = '{2'b01, 2'd3, 20, 18, 3,  1};
    vecs[4] = '{2'b11, 2'd0, 20, 18, 3,  1};
    vecs[5] = '{2'b00, 2'd3, 20, 0,  0,  0};
    vecs[6] = '{2'b10, 2'd0, 20, 0,  0,  0};

    reset      = 1'b1;
    mode_i     = 2'b00;
    rate_sel_i = 2'd0;
    step_btn_i = 1'b0;
    #2;

    for (int i = 0; i < 7; i++) begin
      do_reset(vecs[i].mode, vecs[i].rate, 1'b0);
      exp_q.push_back(vecs[i]);
      wait_edges(vecs[i].n);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_ticks", i), tick_q.size(), e.exp_ticks);
      chk($sformatf("vec%0d_first", i), first_tick(), e.exp_first);
      chk($sformatf("vec%0d_running", i), int'(running_o), e.exp_run);
    end

    // RUN div 8, rate switched to div 4 so that it lands with cnt=6.
    do_reset(2'b01, 2'd1, 1'b0);
    wait_edges(6);
    rate_sel_i = 2'd0;
    wait_edges(14);
    chk("ratechg_count", tick_q.size(), 3);
    if (tick_q.size() == 3) begin
      chk("ratechg_t0", tick_q[0] - base, 9);
      chk("ratechg_t1", tick_q[1] - base, 13);
      chk("ratechg_t2", tick_q[2] - base, 17);
    end

    // STEP: held press gives one tick 2 sync + 3 debounce edges later.
    do_reset(2'b10, 2'd0, 1'b0);
    wait_edges(4);
    press = cyc;
    step_btn_i = 1'b1;
    wait_edges(20);
    chk("step_hold_count", tick_q.size(), 1);
    if (tick_q.size() == 1) chk("step_hold_time", tick_q[0] - press, 5);
    step_btn_i = 1'b0;
    wait_edges(10);
    chk("step_release_count", tick_q.size(), 1);

    tick_q.delete();
    for (int g = 0; g < 3; g++) begin
      step_btn_i = 1'b1;
      wait_edges(2);
      step_btn_i = 1'b0;
      wait_edges(4);
    end
    chk("step_glitch_count", tick_q.size(), 0);

    // Exactly DEBOUNCE_CYC cycles of press is accepted.
    press = cyc;
    step_btn_i = 1'b1;
    wait_edges(3);
    step_btn_i = 1'b0;
    wait_edges(10);
    chk("step_min_count", tick_q.size(), 1);
    if (tick_q.size() == 1) chk("step_min_time", tick_q[0] - press, 5);

    // Press taken in HALT, then STEP entered while held: no tick.
    do_reset(2'b00, 2'd0, 1'b0);
    wait_edges(4);
    step_btn_i = 1'b1;
    wait_edges(10);
    mode_i = 2'b10;
    wait_edges(10);
    chk("halt_press_count", tick_q.size(), 0);
    chk("halt_press_running", int'(running_o), 0);
    step_btn_i = 1'b0;

    // FAST then HALT: tick stops within 3 edges.
    do_reset(2'b11, 2'd0, 1'b0);
    wait_edges(6);
    chk("fast_count", tick_q.size(), 4);
    chk("fast_tick_level", int'(tick_o), 1);
    mode_i = 2'b00;
    wait_edges(3);
    chk("halt_tick", int'(tick_o), 0);
    chk("halt_running", int'(running_o), 0);
    wait_edges(5);
    chk("halt_total", tick_q.size(), 6);

    // 17 ticks at div 1 wrap a 4-bit counter to 1.
    do_reset(2'b01, 2'd3, 1'b0);
    wait_edges(19);
    chk("cnt17_ticks", tick_q.size(), 17);
`ifdef CPU_TICK_CNT_EN
    chk("cnt17_wrap", int'(tick_cnt_o), 1);
`endif

    // Reset during a FAST pulse drops tick_o at once.
    do_reset(2'b11, 2'd0, 1'b0);
    wait_edges(5);
    chk("pre_rst_tick", int'(tick_o), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_tick", int'(tick_o), 0);

    // Reset mid-RUN with cnt=2, then restart with RUN held on the pin.
    do_reset(2'b01, 2'd0, 1'b0);
    wait_edges(12);
    chk("midrun_ticks", tick_q.size(), 2);
`ifdef CPU_TICK_CNT_EN
    chk("midrun_cnt", int'(tick_cnt_o), 2);
`endif
    reset = 1'b0;
    #1;
    chk("midrun_rst_tick", int'(tick_o), 0);
    chk("midrun_rst_running", int'(running_o), 0);
`ifdef CPU_TICK_CNT_EN
    chk("midrun_rst_cnt", int'(tick_cnt_o), 0);
`endif
    do_reset(2'b01, 2'd0, 1'b0);
    wait_edges(2);
    chk("restart_running", int'(running_o), 1);
    wait_edges(6);
    chk("restart_count", tick_q.size(), 1);
    chk("restart_first", first_tick(), 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
